// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stage enables and bubble/flush controls for the 5-stage core.
// Define HAZARD_FWD_EN when a forwarding path exists (only load-use stalls).
module hazard_ctrl #(
    parameter int REG_AW    = 3,
    parameter int MEM_LAT   = 2,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic              dec_rs1_used,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_rs2_used,
    input  logic              dec_halt,
    input  logic [REG_AW-1:0] ex_write_reg,
    input  logic              ex_write_en,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_write_reg,
    input  logic              mem_write_en,
    input  logic              mem_req,
    input  logic              ex_flush,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              halted,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_t;

    localparam int WAIT_W  = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC);

    state_t              state_q, state_d, ret_q, ret_d, cur_state;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                raw;
    logic                mem_stall;
    logic                freeze, do_run, do_drain;

`ifdef HAZARD_FWD_EN
    logic ex_load;
    logic unused_mem_fields;
    assign ex_load = ex_mem_read && ex_write_en;
    assign raw = (dec_rs1_used && ex_load && (ex_write_reg == dec_rs1)) ||
                 (dec_rs2_used && ex_load && (ex_write_reg == dec_rs2));
    assign unused_mem_fields = ^{mem_write_reg, mem_write_en};
`else
    logic rs1_hit, rs2_hit;
    logic unused_load_flag;
    assign rs1_hit = (ex_write_en && (ex_write_reg == dec_rs1)) ||
                     (mem_write_en && (mem_write_reg == dec_rs1));
    assign rs2_hit = (ex_write_en && (ex_write_reg == dec_rs2)) ||
                     (mem_write_en && (mem_write_reg == dec_rs2));
    assign raw = (dec_rs1_used && rs1_hit) || (dec_rs2_used && rs2_hit);
    assign unused_load_flag = ex_mem_read;
`endif

    assign mem_stall = mem_req && (MEM_LAT > 1);
    // Reset forces the RUN view of the outputs even before the register clears.
    assign cur_state = rst ? RUN : state_q;
    assign state     = cur_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            wait_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
        end
    end

    // Classify the cycle: frozen, normal running control, or drain control.
    // The MEMWAIT release cycle behaves as the state it returns to.
    always_comb begin
        freeze   = 1'b0;
        do_run   = 1'b0;
        do_drain = 1'b0;
        case (cur_state)
            RUN: begin
                if (mem_stall) freeze = 1'b1;
                else           do_run = 1'b1;
            end
            MEMWAIT: begin
                if (wait_q != '0)        freeze   = 1'b1;
                else if (ret_q == DRAIN) do_drain = 1'b1;
                else                     do_run   = 1'b1;
            end
            DRAIN: begin
                if (mem_stall) freeze   = 1'b1;
                else           do_drain = 1'b1;
            end
            default: freeze = 1'b1;
        endcase
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halted      = (cur_state == HALTED);
        if (freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (do_drain) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (ex_flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (raw) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = cur_state;
        ret_d   = ret_q;
        wait_d  = wait_q;
        drain_d = drain_q;
        if (freeze) begin
            if (cur_state == MEMWAIT) begin
                wait_d = wait_q - WAIT_W'(1);
            end else if (cur_state != HALTED) begin
                // A new access from RUN or DRAIN: remember where to resume.
                state_d = MEMWAIT;
                ret_d   = cur_state;
                wait_d  = WAIT_LOAD;
            end
        end else if (do_drain) begin
            drain_d = drain_q - DRAIN_W'(1);
            state_d = (drain_q == DRAIN_W'(1)) ? HALTED : DRAIN;
        end else if (do_run) begin
            state_d = RUN;
            if (!ex_flush && !raw && dec_halt) begin
                state_d = DRAIN;
                drain_d = DRAIN_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (MEM_LAT=2 and 3) against a cycle-count model.
module tb_hazard_ctrl;

    localparam int AW = 3;
    localparam int DRAIN_N = 3;

    // {state, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, halted}
    localparam logic [9:0] RUN_ALL  = 10'b00_11111_000;
    localparam logic [9:0] STALL    = 10'b00_00111_010;
    localparam logic [9:0] FLUSH    = 10'b00_11111_110;
    localparam logic [9:0] FRZ_RUN  = 10'b00_00000_000;
    localparam logic [9:0] FRZ_WAIT = 10'b01_00000_000;
    localparam logic [9:0] REL_RUN  = 10'b01_11111_000;
    localparam logic [9:0] DRN      = 10'b10_01111_110;
    localparam logic [9:0] FRZ_DRN  = 10'b10_00000_000;
    localparam logic [9:0] REL_DRN  = 10'b01_01111_110;
    localparam logic [9:0] HLT      = 10'b11_00000_001;

    logic clk = 1'b1;
    logic rst;
    logic [AW-1:0] dec_rs1, dec_rs2, ex_write_reg, mem_write_reg;
    logic dec_rs1_used, dec_rs2_used, dec_halt, ex_write_en, ex_mem_read;
    logic mem_write_en, mem_req, ex_flush;

    logic pc2, ifid2, idex2, exmem2, memwb2, ifidfl2, idexfl2, halt2;
    logic pc3, ifid3, idex3, exmem3, memwb3, ifidfl3, idexfl3, halt3;
    logic [1:0] st2, st3;
    logic [9:0] act2, act3;

    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    // Model: remaining freeze cycles, remaining drain cycles, waiting and halted flags.
    bit m_wait[2] = '{0, 0};
    int m_fl[2]   = '{0, 0};
    int m_dr[2]   = '{0, 0};
    bit m_halt[2] = '{0, 0};
    bit n_wait[2] = '{0, 0};
    int n_fl[2]   = '{0, 0};
    int n_dr[2]   = '{0, 0};
    bit n_halt[2] = '{0, 0};

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(AW), .MEM_LAT(2), .DRAIN_CYC(DRAIN_N)) u_dut2 (
        .clk(clk), .rst(rst),
        .dec_rs1(dec_rs1), .dec_rs1_used(dec_rs1_used),
        .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used), .dec_halt(dec_halt),
        .ex_write_reg(ex_write_reg), .ex_write_en(ex_write_en), .ex_mem_read(ex_mem_read),
        .mem_write_reg(mem_write_reg), .mem_write_en(mem_write_en), .mem_req(mem_req),
        .ex_flush(ex_flush),
        .pc_en(pc2), .if_id_en(ifid2), .id_ex_en(idex2), .ex_mem_en(exmem2),
        .mem_wb_en(memwb2), .if_id_flush(ifidfl2), .id_ex_flush(idexfl2),
        .halted(halt2), .state(st2)
    );

    hazard_ctrl #(.REG_AW(AW), .MEM_LAT(3), .DRAIN_CYC(DRAIN_N)) u_dut3 (
        .clk(clk), .rst(rst),
        .dec_rs1(dec_rs1), .dec_rs1_used(dec_rs1_used),
        .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used), .dec_halt(dec_halt),
        .ex_write_reg(ex_write_reg), .ex_write_en(ex_write_en), .ex_mem_read(ex_mem_read),
        .mem_write_reg(mem_write_reg), .mem_write_en(mem_write_en), .mem_req(mem_req),
        .ex_flush(ex_flush),
        .pc_en(pc3), .if_id_en(ifid3), .id_ex_en(idex3), .ex_mem_en(exmem3),
        .mem_wb_en(memwb3), .if_id_flush(ifidfl3), .id_ex_flush(idexfl3),
        .halted(halt3), .state(st3)
    );

    assign act2 = {st2, pc2, ifid2, idex2, exmem2, memwb2, ifidfl2, idexfl2, halt2};
    assign act3 = {st3, pc3, ifid3, idex3, exmem3, memwb3, ifidfl3, idexfl3, halt3};

    function automatic bit raw_m();
`ifdef HAZARD_FWD_EN
        bit load = ex_mem_read && ex_write_en;
        return (dec_rs1_used && load && ex_write_reg == dec_rs1) ||
               (dec_rs2_used && load && ex_write_reg == dec_rs2);
`else
        bit h1 = (ex_write_en && ex_write_reg == dec_rs1) || (mem_write_en && mem_write_reg == dec_rs1);
        bit h2 = (ex_write_en && ex_write_reg == dec_rs2) || (mem_write_en && mem_write_reg == dec_rs2);
        return (dec_rs1_used && h1) || (dec_rs2_used && h2);
`endif
    endfunction

    // Normal running control; ht reports a halt being accepted into EX.
    function automatic logic [7:0] run_out(output bit ht);
        ht = 1'b0;
        if (ex_flush) return 8'b11111_110;
        if (raw_m()) return 8'b00111_010;
        ht = dec_halt;
        return 8'b11111_000;
    endfunction

    task automatic model_step(input int d, output logic [9:0] e);
        int lat;
        bit ht;
        logic [1:0] st;
        logic [7:0] o;
        lat = (d == 0) ? 2 : 3;
        n_wait[d] = m_wait[d];
        n_fl[d]   = m_fl[d];
        n_dr[d]   = m_dr[d];
        n_halt[d] = m_halt[d];
        st = 2'd0;
        o  = 8'h00;
        if (rst) begin
            o = (mem_req && lat > 1) ? 8'h00 : run_out(ht);
            n_wait[d] = 0; n_fl[d] = 0; n_dr[d] = 0; n_halt[d] = 0;
        end else if (m_halt[d]) begin
            st = 2'd3; o = 8'b00000_001;
        end else if (m_wait[d] && m_fl[d] > 0) begin
            st = 2'd1; n_fl[d] = m_fl[d] - 1;
        end else if (m_wait[d]) begin
            st = 2'd1; n_wait[d] = 0;
            if (m_dr[d] > 0) begin
                o = 8'b01111_110; n_dr[d] = m_dr[d] - 1; n_halt[d] = (n_dr[d] == 0);
            end else begin
                o = run_out(ht);
                if (ht) n_dr[d] = DRAIN_N;
            end
        end else if (m_dr[d] > 0) begin
            st = 2'd2;
            if (mem_req && lat > 1) begin
                n_wait[d] = 1; n_fl[d] = lat - 2;
            end else begin
                o = 8'b01111_110; n_dr[d] = m_dr[d] - 1; n_halt[d] = (n_dr[d] == 0);
            end
        end else begin
            if (mem_req && lat > 1) begin
                n_wait[d] = 1; n_fl[d] = lat - 2;
            end else begin
                o = run_out(ht);
                if (ht) n_dr[d] = DRAIN_N;
            end
        end
        e = {st, o};
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
    endtask

    // Compare process: model every cycle, plus any hand-computed vectors queued for this cycle.
    always @(negedge clk) begin
        logic [9:0] e;
        logic [10:0] ent;
        model_step(0, e);
        check("model_lat2", act2, e);
        model_step(1, e);
        check("model_lat3", act3, e);
        while (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            if (ent[10]) check("lit_lat3", act3, ent[9:0]);
            else         check("lit_lat2", act2, ent[9:0]);
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_wait[d] = n_wait[d];
            m_fl[d]   = n_fl[d];
            m_dr[d]   = n_dr[d];
            m_halt[d] = n_halt[d];
        end
    end

    task automatic idle();
        dec_rs1 = '0; dec_rs1_used = 0; dec_rs2 = '0; dec_rs2_used = 0; dec_halt = 0;
        ex_write_reg = '0; ex_write_en = 0; ex_mem_read = 0;
        mem_write_reg = '0; mem_write_en = 0; mem_req = 0; ex_flush = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic lit(input int sel, input logic [9:0] v);
        exp_q.push_back({(sel != 0), v});
    endtask

    task automatic lit2(input logic [9:0] v);
        lit(0, v);
        lit(1, v);
    endtask

    initial begin
        rst = 1; idle(); lit2(RUN_ALL);
        next_cyc(); mem_req = 1; lit2(FRZ_RUN);
        next_cyc(); rst = 0; lit2(RUN_ALL);
        // Load-use on rs1, then clear.
        next_cyc(); ex_mem_read = 1; ex_write_en = 1; ex_write_reg = 2; dec_rs1 = 2; dec_rs1_used = 1; lit2(STALL);
        next_cyc(); dec_rs1 = 2; dec_rs1_used = 1; lit2(RUN_ALL);
        // MEM writer r5 and EX non-load writer r0.
        next_cyc(); mem_write_en = 1; mem_write_reg = 5; dec_rs2 = 5; dec_rs2_used = 1;
`ifdef HAZARD_FWD_EN
        lit2(RUN_ALL);
`else
        lit2(STALL);
`endif
        next_cyc(); ex_write_en = 1; ex_write_reg = 0; dec_rs2 = 0; dec_rs2_used = 1;
`ifdef HAZARD_FWD_EN
        lit2(RUN_ALL);
`else
        lit2(STALL);
`endif
        next_cyc(); ex_mem_read = 1; ex_write_en = 1; ex_write_reg = 4; dec_rs1 = 4; dec_rs2 = 3; dec_rs2_used = 1; lit2(RUN_ALL);
        next_cyc(); ex_mem_read = 1; ex_write_en = 1; ex_write_reg = 6; dec_rs2 = 6; dec_rs2_used = 1; lit2(STALL);
        // Flush beats a load-use hazard and a halt in decode.
        next_cyc(); ex_flush = 1; ex_mem_read = 1; ex_write_en = 1; ex_write_reg = 2;
        dec_rs1 = 2; dec_rs1_used = 1; dec_halt = 1; lit2(FLUSH);
        next_cyc(); lit2(RUN_ALL);
        // Single memory access pulse.
        next_cyc(); mem_req = 1; lit2(FRZ_RUN);
        next_cyc(); lit(0, REL_RUN); lit(1, FRZ_WAIT);
        next_cyc(); lit(0, RUN_ALL); lit(1, REL_RUN);
        next_cyc(); lit2(RUN_ALL);
        // Halt and drain without an access, then reset out of HALTED.
        next_cyc(); dec_halt = 1; lit2(RUN_ALL);
        for (int i = 0; i < 3; i++) begin
            next_cyc(); lit2(DRN);
        end
        next_cyc(); ex_flush = 1; mem_req = 1; lit2(HLT);
        next_cyc(); lit2(HLT);
        next_cyc(); rst = 1; lit2(RUN_ALL);
        next_cyc(); rst = 0; lit2(RUN_ALL);
        // Halt and drain with one access in the middle.
        next_cyc(); dec_halt = 1; lit2(RUN_ALL);
        next_cyc(); lit2(DRN);
        next_cyc(); mem_req = 1; lit2(FRZ_DRN);
        next_cyc(); lit(0, REL_DRN); lit(1, FRZ_WAIT);
        next_cyc(); lit(0, DRN); lit(1, REL_DRN);
        next_cyc(); lit(0, HLT); lit(1, DRN);
        next_cyc(); lit2(HLT);
        next_cyc(); rst = 1; lit2(RUN_ALL);
        next_cyc(); rst = 0; lit2(RUN_ALL);
        // Reset aborting MEMWAIT and DRAIN.
        next_cyc(); mem_req = 1; lit2(FRZ_RUN);
        next_cyc(); rst = 1; lit2(RUN_ALL);
        next_cyc(); rst = 0; lit2(RUN_ALL);
        next_cyc(); dec_halt = 1; lit2(RUN_ALL);
        next_cyc(); rst = 1; lit2(RUN_ALL);
        next_cyc(); rst = 0; lit2(RUN_ALL);
        // Mixed traffic checked by the model only.
        for (int i = 0; i < 400; i++) begin
            next_cyc();
            rst = ($urandom_range(0, 39) == 0);
            dec_rs1 = AW'($urandom_range(0, 3)); dec_rs1_used = $urandom_range(0, 1) == 1;
            dec_rs2 = AW'($urandom_range(0, 3)); dec_rs2_used = $urandom_range(0, 1) == 1;
            dec_halt = ($urandom_range(0, 15) == 0);
            ex_write_reg = AW'($urandom_range(0, 3)); ex_write_en = $urandom_range(0, 1) == 1;
            ex_mem_read = $urandom_range(0, 1) == 1;
            mem_write_reg = AW'($urandom_range(0, 3)); mem_write_en = $urandom_range(0, 1) == 1;
            mem_req = ($urandom_range(0, 5) == 0);
            ex_flush = ($urandom_range(0, 7) == 0);
        end
        next_cyc();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
